// File: rtl/twophase_sync_fifo_pkg.sv
// Shared constants for the two-phase FIFO: reset phase, default sizes and
// a constant-evaluable clog2 used to derive pointer and occupancy widths.
package mousetrap_pkg;

    localparam logic PHASE_RESET = 1'b0;

    localparam int WORD_WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/twophase_sync_fifo_if.sv
// Two-phase bundled-data link bundle around the FIFO.
// slave: FIFO view (req_in/Data_in/ack_out in), master: environment view.
interface twophase_sync_fifo_if
    import mousetrap_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic req_in;
    logic [WORD_WIDTH-1:0] Data_in;
    logic ack_in;
    logic req_out;
    logic [WORD_WIDTH-1:0] Data_out;
    logic ack_out;
    logic [CNT_W-1:0] occupancy;

    modport slave (
        input  req_in,
        input  Data_in,
        output ack_in,
        output req_out,
        output Data_out,
        input  ack_out,
        output occupancy
    );

    modport master (
        output req_in,
        output Data_in,
        input  ack_in,
        input  req_out,
        input  Data_out,
        output ack_out,
        input  occupancy
    );

endinterface

// File: rtl/twophase_sync.sv
// 1-bit two-flop synchroniser for transition-signalled handshake lines.
// Ports: clk, rst (async high, clears to phase 0), d (async in), q (synced).
module twophase_sync
    import mousetrap_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= PHASE_RESET;
            q    <= PHASE_RESET;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/twophase_sync_fifo.sv
// DEPTH-entry bundled-data FIFO with two-phase req/ack on both sides.
// Ports: clk, rst (async high), bus (slave: req/Data/ack in+out, occupancy).
// Build option TWOPHASE_SYNC_EN: synchronise req_in and ack_out (2 flops).
module twophase_sync_fifo
    import mousetrap_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
)(
    input logic clk,
    input logic rst,
    twophase_sync_fifo_if.slave bus
);
    localparam int CNT_W = clog2(DEPTH) + 1;
    localparam int AW = clog2(DEPTH);

    logic req_in_s;
    logic ack_out_s;

`ifdef TWOPHASE_SYNC_EN
    twophase_sync u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.req_in),
        .q   (req_in_s)
    );

    twophase_sync u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ack_out),
        .q   (ack_out_s)
    );
`else
    assign req_in_s  = bus.req_in;
    assign ack_out_s = bus.ack_out;
`endif

    logic ack_in_q;
    logic req_out_q;
    logic [WORD_WIDTH-1:0] data_out_q;
    logic [CNT_W-1:0] occ_q;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic in_pend;
    logic out_free;
    logic wr_en;
    logic rd_en;

    assign in_pend  = req_in_s ^ ack_in_q;
    assign out_free = (req_out_q == ack_out_s);

    // Full test uses the registered count, so a read on the same edge
    // does not open a slot for a write.
    assign wr_en = in_pend && (occ_q < CNT_W'(DEPTH));
    assign rd_en = out_free && (occ_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_in_q   <= PHASE_RESET;
            req_out_q  <= PHASE_RESET;
            data_out_q <= '0;
            occ_q      <= '0;
            wp         <= '0;
            rp         <= '0;
        end else begin
            if (wr_en) begin
                wp       <= wp + AW'(1);
                ack_in_q <= ~ack_in_q;
            end
            if (rd_en) begin
                data_out_q <= mem[rp];
                rp         <= rp + AW'(1);
                req_out_q  <= ~req_out_q;
            end
            unique case ({wr_en, rd_en})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is not reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= bus.Data_in;
        end
    end

    assign bus.ack_in    = ack_in_q;
    assign bus.req_out   = req_out_q;
    assign bus.Data_out  = data_out_q;
    assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_twophase_sync_fifo.sv
// Directed bench for twophase_sync_fifo (WORD_WIDTH=32, DEPTH=4).
// Plays same-clock producer and consumer; checks order, latency, occupancy.
module tb_twophase_sync_fifo;
    localparam int WW = 32;
    localparam int DEPTH = 4;
`ifdef TWOPHASE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic rst;
    int n_cmp;
    int n_err;

    twophase_sync_fifo_if #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) bus ();

    twophase_sync_fifo #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_in = 1'b0;
        bus.ack_out = 1'b0;
        bus.Data_in = '0;
        #2;
        n_cmp++;
        if (bus.ack_in !== 1'b0 || bus.req_out !== 1'b0 ||
            bus.Data_out !== '0 || bus.occupancy !== '0) begin
            n_err++;
            $display("FAIL reset: ack_in=%b req_out=%b data=%h occ=%0d want 0",
                     bus.ack_in, bus.req_out, bus.Data_out, bus.occupancy);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.Data_in = 32'hA5A5_0001;
        bus.req_in = 1'b1;
        repeat (SYNC_LAT + 1) tick();
        n_cmp++;
        if (bus.ack_in !== 1'b1 || bus.req_out !== 1'b0 ||
            bus.occupancy !== 3'd1) begin
            n_err++;
            $display("FAIL single_accept: ack_in=%b req_out=%b occ=%0d want 1 0 1",
                     bus.ack_in, bus.req_out, bus.occupancy);
        end
        tick();
        n_cmp++;
        if (bus.req_out !== 1'b1 || bus.Data_out !== 32'hA5A5_0001 ||
            bus.occupancy !== 3'd0) begin
            n_err++;
            $display("FAIL single_present: req_out=%b data=%h occ=%0d want 1 a5a50001 0",
                     bus.req_out, bus.Data_out, bus.occupancy);
        end
        bus.ack_out = 1'b1;
        repeat (SYNC_LAT + 2) tick();
        n_cmp++;
        if (bus.req_out !== 1'b1 || bus.Data_out !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL single_hold: req_out=%b data=%h want 1 a5a50001",
                     bus.req_out, bus.Data_out);
        end
    endtask

    task automatic send_wait(input logic [WW-1:0] d, input string nm);
        int k;
        bus.Data_in = d;
        bus.req_in = ~bus.req_in;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.ack_in !== bus.req_in && k < 20);
        n_cmp++;
        if (bus.ack_in !== bus.req_in) begin
            n_err++;
            $display("FAIL %s: ack_in=%b want %b (timeout)", nm, bus.ack_in, bus.req_in);
        end
    endtask

    task automatic recv(input logic [WW-1:0] exp, input string nm);
        int k;
        k = 0;
        while (bus.req_out === bus.ack_out && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (bus.req_out === bus.ack_out || bus.Data_out !== exp) begin
            n_err++;
            $display("FAIL %s: req_out=%b data=%h want token %h",
                     nm, bus.req_out, bus.Data_out, exp);
        end
        bus.ack_out = ~bus.ack_out;
        tick();
    endtask

    task automatic test_fill();
        logic [WW-1:0] d [6];
        for (int i = 0; i < 6; i++) d[i] = 32'h1000_0000 + WW'(i);
        for (int i = 0; i < 5; i++) send_wait(d[i], "fill_accept");
        n_cmp++;
        if (bus.occupancy !== 3'd4 || bus.Data_out !== d[0] ||
            bus.req_out === bus.ack_out) begin
            n_err++;
            $display("FAIL fill_full: occ=%0d data=%h want 4 %h",
                     bus.occupancy, bus.Data_out, d[0]);
        end
        bus.Data_in = d[5];
        bus.req_in = ~bus.req_in;
        repeat (SYNC_LAT + 3) tick();
        n_cmp++;
        if (bus.ack_in === bus.req_in || bus.occupancy !== 3'd4) begin
            n_err++;
            $display("FAIL fill_withheld: ack_in=%b occ=%0d want %b 4",
                     bus.ack_in, bus.occupancy, ~bus.req_in);
        end
        bus.ack_out = ~bus.ack_out;
        repeat (SYNC_LAT + 1) tick();
        n_cmp++;
        if (bus.Data_out !== d[1] || bus.occupancy !== 3'd3 ||
            bus.ack_in === bus.req_in) begin
            n_err++;
            $display("FAIL fill_read_no_write: data=%h occ=%0d want %h 3",
                     bus.Data_out, bus.occupancy, d[1]);
        end
        tick();
        n_cmp++;
        if (bus.ack_in !== bus.req_in || bus.occupancy !== 3'd4) begin
            n_err++;
            $display("FAIL fill_late_accept: ack_in=%b occ=%0d want %b 4",
                     bus.ack_in, bus.occupancy, bus.req_in);
        end
        for (int i = 1; i < 6; i++) recv(d[i], "fill_order");
        repeat (SYNC_LAT + 2) tick();
        n_cmp++;
        if (bus.occupancy !== 3'd0 || bus.req_out !== bus.ack_out) begin
            n_err++;
            $display("FAIL fill_drained: occ=%0d req_out=%b want 0 %b",
                     bus.occupancy, bus.req_out, bus.ack_out);
        end
    endtask

    task automatic stream(input int n, input int stall, input logic [WW-1:0] base,
                          input string nm, output int max_occ);
        logic [WW-1:0] q [$];
        int sent;
        int got;
        int cyc;
        sent = 0;
        got = 0;
        cyc = 0;
        max_occ = 0;
        while (got < n && cyc < 3000) begin
            if (sent < n && bus.ack_in === bus.req_in &&
                $urandom_range(99) >= stall) begin
                bus.Data_in = base + WW'(sent);
                bus.req_in = ~bus.req_in;
                q.push_back(base + WW'(sent));
                sent++;
            end
            if (bus.req_out !== bus.ack_out && $urandom_range(99) >= stall) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s: spurious token %h, none outstanding",
                             nm, bus.Data_out);
                end else begin
                    if (bus.Data_out !== q[0]) begin
                        n_err++;
                        $display("FAIL %s: data=%h want %h", nm, bus.Data_out, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
                bus.ack_out = ~bus.ack_out;
            end
            tick();
            cyc++;
            if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
        end
        n_cmp++;
        if (got != n) begin
            n_err++;
            $display("FAIL %s_count: received %0d want %0d", nm, got, n);
        end
    endtask

    task automatic test_concurrent();
        int mo;
        stream(10, 0, 32'hC0DE_0000, "concurrent", mo);
        n_cmp++;
        if (SYNC_LAT == 0 && mo > 1) begin
            n_err++;
            $display("FAIL concurrent_occ: max occ=%0d want <=1", mo);
        end
    endtask

    task automatic test_wrap();
        int mo;
        stream(3 * DEPTH + 1, 40, 32'hFACE_0000, "wrap", mo);
        n_cmp++;
        if (mo > DEPTH) begin
            n_err++;
            $display("FAIL wrap_occ: max occ=%0d want <=%0d", mo, DEPTH);
        end
    endtask

    task automatic test_reset_recovery();
        int mo;
        for (int i = 0; i < 4; i++) send_wait(32'hDEAD_0000 + WW'(i), "rr_accept");
        n_cmp++;
        if (bus.occupancy !== 3'd3) begin
            n_err++;
            $display("FAIL rr_occ3: occ=%0d want 3", bus.occupancy);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.ack_in !== 1'b0 || bus.req_out !== 1'b0 ||
            bus.Data_out !== '0 || bus.occupancy !== '0) begin
            n_err++;
            $display("FAIL rr_async: ack_in=%b req_out=%b data=%h occ=%0d want 0",
                     bus.ack_in, bus.req_out, bus.Data_out, bus.occupancy);
        end
        bus.req_in = 1'b0;
        bus.ack_out = 1'b0;
        bus.Data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        repeat (SYNC_LAT + 2) tick();
        n_cmp++;
        if (bus.req_out !== 1'b0 || bus.occupancy !== '0 || bus.ack_in !== 1'b0) begin
            n_err++;
            $display("FAIL rr_idle: req_out=%b ack_in=%b occ=%0d want 0 0 0",
                     bus.req_out, bus.ack_in, bus.occupancy);
        end
        stream(3, 0, 32'hBEEF_0000, "rr_flow", mo);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_fill();
        test_concurrent();
        test_wrap();
        test_reset_recovery();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
